// File: rtl/shift_receiver_framed.sv
// Framed serial-to-parallel receiver: assembles WIDTH-bit words while enable is high,
// rejects runt/overflow frames and queues good words in a DEPTH-entry valid/ready FIFO.
module shift_receiver_framed #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned DEPTH     = 4,
  parameter bit          MSB_FIRST = 1'b1,
  parameter int unsigned ERR_CNT_W = 8
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 enable,
  input  logic                 signal_in,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     signal_out,
  output logic                 out_valid,
  output logic                 fifo_full,
  output logic [ERR_CNT_W-1:0] runt_cnt,
  output logic [ERR_CNT_W-1:0] ovf_cnt,
  output logic [ERR_CNT_W-1:0] drop_cnt,
  output logic                 err_pulse
);

  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(WIDTH);
  localparam logic [OCC_W-1:0] FULL_OCC = OCC_W'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_OVER} state_t;

  state_t               r_state, w_state_nxt;
  logic [WIDTH-1:0]     r_sreg;
  logic [CNT_W-1:0]     r_bit_cnt;
  logic [WIDTH-1:0]     r_mem [DEPTH];
  logic [PTR_W-1:0]     r_wr_ptr, r_rd_ptr;
  logic [OCC_W-1:0]     r_occ;
  logic [ERR_CNT_W-1:0] r_runt, r_ovf, r_drop;
  logic                 r_err;

  logic w_first, w_shift, w_clr, w_push, w_runt, w_ovf;
  logic w_pop, w_wr, w_drop;

  function automatic logic [WIDTH-1:0] f_shift(input logic [WIDTH-1:0] s, input logic b);
    if (MSB_FIRST) f_shift = {s[WIDTH-2:0], b};
    else           f_shift = {b, s[WIDTH-1:1]};
  endfunction

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_first     = 1'b0;
    w_shift     = 1'b0;
    w_clr       = 1'b0;
    w_push      = 1'b0;
    w_runt      = 1'b0;
    w_ovf       = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (enable) begin
          w_first     = 1'b1;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (enable) begin
          if (r_bit_cnt == FULL_CNT) w_state_nxt = S_OVER;
          else                       w_shift     = 1'b1;
        end else begin
          w_clr       = 1'b1;
          w_push      = (r_bit_cnt == FULL_CNT);
          w_runt      = (r_bit_cnt != FULL_CNT);
          w_state_nxt = S_IDLE;
        end
      end
      S_OVER: begin
        if (!enable) begin
          w_ovf       = 1'b1;
          w_clr       = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_clr) begin
      r_sreg    <= '0;
      r_bit_cnt <= '0;
    end else if (w_first) begin
      r_sreg    <= f_shift('0, signal_in);
      r_bit_cnt <= CNT_W'(1);
    end else if (w_shift) begin
      r_sreg    <= f_shift(r_sreg, signal_in);
      r_bit_cnt <= r_bit_cnt + CNT_W'(1);
    end
  end

  // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
  assign w_pop  = out_valid && out_ready;
  assign w_wr   = w_push && (!fifo_full || w_pop);
  assign w_drop = w_push && fifo_full && !w_pop;

  always_ff @(posedge CLK) begin
    if (w_wr) r_mem[r_wr_ptr] <= r_sreg;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_occ    <= '0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      if (w_wr && !w_pop)      r_occ <= r_occ + OCC_W'(1);
      else if (!w_wr && w_pop) r_occ <= r_occ - OCC_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_runt <= '0;
      r_ovf  <= '0;
      r_drop <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_runt && (r_runt != '1)) r_runt <= r_runt + ERR_CNT_W'(1);
      if (w_ovf  && (r_ovf  != '1)) r_ovf  <= r_ovf  + ERR_CNT_W'(1);
      if (w_drop && (r_drop != '1)) r_drop <= r_drop + ERR_CNT_W'(1);
      r_err <= w_runt | w_ovf | w_drop;
    end
  end

  // Head word is masked while empty so reset and drained states read as zero.
  assign out_valid  = (r_occ != '0);
  assign fifo_full  = (r_occ == FULL_OCC);
  assign signal_out = out_valid ? r_mem[r_rd_ptr] : '0;
  assign runt_cnt   = r_runt;
  assign ovf_cnt    = r_ovf;
  assign drop_cnt   = r_drop;
  assign err_pulse  = r_err;

endmodule

// File: tb/tb_shift_receiver_framed.sv
// Bench for shift_receiver_framed: MSB-first and LSB-first instances share stimulus;
// a cycle model with an expected-word queue checks outputs and counters every cycle.
module tb_shift_receiver_framed;
  localparam int unsigned W  = 16;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned SAT = (1 << CW) - 1;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic          enable = 1'b0;
  logic          signal_in = 1'b0;
  logic          out_ready = 1'b0;
  logic [W-1:0]  signal_out, signal_out_l;
  logic          out_valid, out_valid_l, fifo_full, fifo_full_l, err_pulse, err_pulse_l;
  logic [CW-1:0] runt_cnt, ovf_cnt, drop_cnt, runt_cnt_l, ovf_cnt_l, drop_cnt_l;

  shift_receiver_framed #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b1), .ERR_CNT_W(CW)) u_dut (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .signal_in(signal_in), .out_ready(out_ready),
    .signal_out(signal_out), .out_valid(out_valid), .fifo_full(fifo_full),
    .runt_cnt(runt_cnt), .ovf_cnt(ovf_cnt), .drop_cnt(drop_cnt), .err_pulse(err_pulse)
  );

  shift_receiver_framed #(.WIDTH(W), .DEPTH(D), .MSB_FIRST(1'b0), .ERR_CNT_W(CW)) u_dut_lsb (
    .CLK(CLK), .RST_N(RST_N), .enable(enable), .signal_in(signal_in), .out_ready(out_ready),
    .signal_out(signal_out_l), .out_valid(out_valid_l), .fifo_full(fifo_full_l),
    .runt_cnt(runt_cnt_l), .ovf_cnt(ovf_cnt_l), .drop_cnt(drop_cnt_l), .err_pulse(err_pulse_l)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] rev(input logic [W-1:0] x);
    logic [W-1:0] r;
    for (int i = 0; i < W; i++) r[i] = x[W-1-i];
    return r;
  endfunction

  // Reference model: frame tracker plus expected-word scoreboard queue.
  logic [W-1:0] mq[$];
  int           m_state;
  int unsigned  m_cnt, m_runt, m_ovf, m_drop;
  logic [W-1:0] m_word;
  logic         m_err;

  always @(negedge CLK) begin
    logic ev, push, pop;
    logic [W-1:0] pw;
    if (!RST_N) begin
      mq.delete();
      m_state = 0; m_cnt = 0; m_word = '0;
      m_runt = 0; m_ovf = 0; m_drop = 0; m_err = 1'b0;
    end
    chk("out_valid", out_valid, mq.size() > 0);
    chk("signal_out", signal_out, (mq.size() > 0) ? mq[0] : '0);
    chk("out_valid_lsb", out_valid_l, mq.size() > 0);
    chk("signal_out_lsb", signal_out_l, (mq.size() > 0) ? rev(mq[0]) : '0);
    chk("fifo_full", fifo_full, mq.size() == D);
    chk("err_pulse", err_pulse, m_err);
    chk("err_pulse_lsb", err_pulse_l, m_err);
    chk("runt_cnt", runt_cnt, m_runt);
    chk("ovf_cnt", ovf_cnt, m_ovf);
    chk("drop_cnt", drop_cnt, m_drop);
    if (RST_N) begin
      ev = 1'b0; push = 1'b0; pw = '0;
      pop = (mq.size() > 0) && out_ready;
      case (m_state)
        0: if (enable) begin m_word = W'(signal_in); m_cnt = 1; m_state = 1; end
        1: begin
          if (enable) begin
            if (m_cnt == W) m_state = 2;
            else begin m_word = {m_word[W-2:0], signal_in}; m_cnt++; end
          end else begin
            if (m_cnt == W) begin push = 1'b1; pw = m_word; end
            else begin ev = 1'b1; if (m_runt < SAT) m_runt++; end
            m_cnt = 0; m_word = '0; m_state = 0;
          end
        end
        default: if (!enable) begin
          ev = 1'b1; if (m_ovf < SAT) m_ovf++;
          m_cnt = 0; m_word = '0; m_state = 0;
        end
      endcase
      if (pop) void'(mq.pop_front());
      if (push) begin
        if (mq.size() < D) mq.push_back(pw);
        else begin ev = 1'b1; if (m_drop < SAT) m_drop++; end
      end
      m_err = ev;
    end
  end

  task automatic cyc(input logic en, input logic b, input logic r);
    enable = en; signal_in = b; out_ready = r;
    @(posedge CLK); #1;
  endtask

  task automatic send_frame(input int unsigned n, input logic [63:0] data, input logic r);
    for (int unsigned i = 0; i < n; i++) cyc(1'b1, data[n-1-i], r);
    cyc(1'b0, 1'b0, r);
  endtask

  task automatic idle(input int unsigned n, input logic r);
    for (int unsigned i = 0; i < n; i++) cyc(1'b0, 1'b0, r);
  endtask

  typedef struct {
    int unsigned nbits;
    logic [63:0] data;
    logic        rdy;
    int unsigned e_runt;
    int unsigned e_ovf;
  } vec_t;

  vec_t tbl[5];

  initial begin
    tbl[0] = '{16, 64'hA5C3,  1'b1, 0, 0};
    tbl[1] = '{10, 64'h2AB,   1'b1, 1, 0};
    tbl[2] = '{20, 64'hFACE1, 1'b1, 1, 1};
    tbl[3] = '{16, 64'h1234,  1'b1, 1, 1};
    tbl[4] = '{1,  64'h1,     1'b1, 2, 1};

    @(negedge CLK); #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_signal_out", signal_out, '0);
    chk("rst_runt", runt_cnt, '0);
    @(posedge CLK); #1;
    RST_N = 1'b1;
    idle(2, 1'b1);

    for (int unsigned i = 0; i < 5; i++) begin
      send_frame(tbl[i].nbits, tbl[i].data, tbl[i].rdy);
      idle(3, 1'b1);
      chk("tbl_runt", runt_cnt, tbl[i].e_runt);
      chk("tbl_ovf", ovf_cnt, tbl[i].e_ovf);
      chk("tbl_drop", drop_cnt, 0);
    end

    // Five back-to-back frames with consumer stalled: the fifth is dropped.
    for (int unsigned k = 1; k <= 5; k++) send_frame(16, 64'h1111 * k, 1'b0);
    idle(3, 1'b0);
    chk("stall_full", fifo_full, 1'b1);
    chk("stall_drop", drop_cnt, 1);
    chk("stall_head", signal_out, 16'h1111);
    idle(8, 1'b1);
    chk("drained", out_valid, 1'b0);

    // Full FIFO with a pop in the end-of-frame cycle: no drop, stays full.
    for (int unsigned k = 0; k < 4; k++) send_frame(16, 64'h4000 + k, 1'b0);
    for (int unsigned i = 0; i < 16; i++) cyc(1'b1, i[0], 1'b0);
    cyc(1'b0, 1'b0, 1'b1);
    idle(3, 1'b0);
    chk("coinc_full", fifo_full, 1'b1);
    chk("coinc_drop", drop_cnt, 1);
    chk("coinc_head", signal_out, 16'h4001);
    idle(8, 1'b1);

    // Reset mid-frame with two words queued.
    send_frame(16, 64'hCAFE, 1'b0);
    send_frame(16, 64'hD00D, 1'b0);
    for (int unsigned i = 0; i < 8; i++) cyc(1'b1, 1'b1, 1'b0);
    RST_N = 1'b0;
    #2;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_signal_out", signal_out, '0);
    chk("arst_runt", runt_cnt, '0);
    chk("arst_ovf", ovf_cnt, '0);
    chk("arst_drop", drop_cnt, '0);
    idle(2, 1'b0);
    RST_N = 1'b1;
    idle(1, 1'b1);
    send_frame(16, 64'hBEEF, 1'b1);
    idle(3, 1'b1);

    // Runt counter saturation.
    for (int unsigned k = 0; k < 260; k++) begin
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b0, 1'b0, 1'b1);
    end
    idle(2, 1'b1);
    chk("runt_sat", runt_cnt, SAT);

    // Enable held high for a long stretch: one overflow on release, no output.
    for (int unsigned i = 0; i < 100; i++) cyc(1'b1, i[1], 1'b1);
    chk("hold_no_out", out_valid, 1'b0);
    chk("hold_ovf_pending", ovf_cnt, 0);
    idle(3, 1'b1);
    chk("hold_ovf", ovf_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
